// File: rtl/gowin_arb_pkg.sv
// rtl/gowin_arb_pkg.sv - shared state encoding and helpers for the register bank arbiter
package gowin_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Never returns 0 so that index ports stay at least one bit wide.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector, first request at or after ptr
module rr_pick
  import gowin_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  function automatic logic [IW-1:0] slot(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && req[slot(ptr, k)]) begin
        valid                = 1'b1;
        gnt[slot(ptr, k)]    = 1'b1;
        idx                  = slot(ptr, k);
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin arbiter and sequencer for a shared register bank
module dff_bank_arbiter
  import gowin_arb_pkg::*;
#(
  parameter int               NREQ  = 4,
  parameter int               WIDTH = 8,
  parameter int               AW    = 3,
  parameter logic [WIDTH-1:0] INIT  = '0,
  localparam int              IW    = clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ-1:0]       LOCK,
  input  logic [NREQ-1:0]       WE,
  input  logic [NREQ*AW-1:0]    ADDR,
  input  logic [NREQ*WIDTH-1:0] WDATA,
  output logic [NREQ-1:0]       GNT,
  output logic                  RVALID,
  output logic [WIDTH-1:0]      RDATA,
  output logic [IW-1:0]         RID,
  output logic                  BUSY
);

  localparam int DEPTH = 2 ** AW;

  arb_state_t       state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    next_ptr;
  logic [WIDTH-1:0] bank [DEPTH];

  logic [NREQ-1:0]  arb_req;
  logic [IW-1:0]    arb_ptr;
  logic [NREQ-1:0]  pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_valid;
  logic [AW-1:0]    acc_addr;
  logic [WIDTH-1:0] acc_wdata;
  logic             stay;

  // The owner's REQ is still the one just served, so it is masked when the grant ends.
  always_comb begin
    next_ptr  = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
    acc_addr  = ADDR[owner*AW +: AW];
    acc_wdata = WDATA[owner*WIDTH +: WIDTH];
    stay      = LOCK[owner] & REQ[owner];
    arb_req   = REQ;
    arb_ptr   = ptr;
    if (state != IDLE) begin
      arb_req[owner] = 1'b0;
      arb_ptr        = next_ptr;
    end
  end

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req   (arb_req),
    .ptr   (arb_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state  <= IDLE;
      ptr    <= '0;
      owner  <= '0;
      GNT    <= '0;
      RVALID <= 1'b0;
      RDATA  <= '0;
      RID    <= '0;
      BUSY   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= INIT;
    end else begin
      RVALID <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= GRANT;
            GNT   <= pick_gnt;
            owner <= pick_idx;
            BUSY  <= 1'b1;
          end
        end
        GRANT, LOCKED: begin
          if (WE[owner]) begin
            bank[acc_addr] <= acc_wdata;
          end else begin
            RVALID <= 1'b1;
            RDATA  <= bank[acc_addr];
            RID    <= owner;
          end
          if (stay) begin
            state <= LOCKED;
          end else begin
            ptr <= next_ptr;
            if (pick_valid) begin
              state <= GRANT;
              GNT   <= pick_gnt;
              owner <= pick_idx;
            end else begin
              state <= IDLE;
              GNT   <= '0;
              BUSY  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - self-checking bench for dff_bank_arbiter
module tb_dff_bank_arbiter;

  localparam logic [7:0] INIT_V = 8'h5A;

  logic        clk;
  logic        resetn;
  logic [3:0]  req, lock, we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        rvalid;
  logic [7:0]  rdata;
  logic [1:0]  rid;
  logic        busy;

  int tests = 0;
  int fails = 0;

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .AW(3), .INIT(INIT_V)) dut (
    .CLK    (clk),
    .RESETN (resetn),
    .REQ    (req),
    .LOCK   (lock),
    .WE     (we),
    .ADDR   (addr),
    .WDATA  (wdata),
    .GNT    (gnt),
    .RVALID (rvalid),
    .RDATA  (rdata),
    .RID    (rid),
    .BUSY   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    resetn = 1'b0;
    for (int i = 0; i < n; i++) step();
    resetn = 1'b1;
  endtask

  task automatic do_txn(input int id, input logic w, input logic [2:0] a,
                        input logic [7:0] d, input logic [7:0] exp);
    req = '0; lock = '0;
    req[id] = 1'b1;
    we[id] = w;
    addr[id*3 +: 3] = a;
    wdata[id*8 +: 8] = d;
    step();
    chk("txn_gnt", gnt, 32'(1) << id);
    chk("txn_busy", busy, 1);
    step();
    chk("txn_rvalid", rvalid, !w);
    if (!w) begin
      chk("txn_rdata", rdata, exp);
      chk("txn_rid", rid, id);
    end
    chk("txn_gnt_end", gnt, 0);
    req = '0;
    step();
    chk("txn_idle", busy, 0);
  endtask

  // Reference model: transaction-level view of owner, pointer and bank contents.
  int         m_owner, m_ptr, m_rid;
  logic [7:0] m_bank [8];
  logic       m_rv;
  logic [7:0] m_rd;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_rv = 1'b0; m_rd = '0; m_rid = 0;
    for (int i = 0; i < 8; i++) m_bank[i] = INIT_V;
  endtask

  task automatic model_edge();
    int o;
    logic [3:0] r;
    logic [2:0] a;
    m_rv = 1'b0;
    if (m_owner < 0) begin
      m_owner = pick(req, m_ptr);
    end else begin
      o = m_owner;
      a = addr[o*3 +: 3];
      if (we[o]) m_bank[a] = wdata[o*8 +: 8];
      else begin
        m_rv = 1'b1; m_rd = m_bank[a]; m_rid = o;
      end
      if (!(lock[o] && req[o])) begin
        m_ptr = (o + 1) % 4;
        r = req;
        r[o] = 1'b0;
        m_owner = pick(r, m_ptr);
      end
    end
  endtask

  task automatic new_access(input int i, input logic keep_lock);
    req[i] = 1'b1;
    we[i] = $urandom_range(0, 1);
    addr[i*3 +: 3] = 3'($urandom_range(0, 7));
    wdata[i*8 +: 8] = 8'($urandom);
    lock[i] = keep_lock;
  endtask

  typedef struct {
    int         id;
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int prev;
    tbl[0] = '{2, 1'b1, 3'd3, 8'hA5, 8'h00};
    tbl[1] = '{2, 1'b0, 3'd3, 8'h00, 8'hA5};
    tbl[2] = '{3, 1'b1, 3'd7, 8'h3C, 8'h00};
    tbl[3] = '{3, 1'b0, 3'd7, 8'h00, 8'h3C};
    tbl[4] = '{3, 1'b0, 3'd0, 8'h00, INIT_V};
    tbl[5] = '{0, 1'b1, 3'd0, 8'h11, 8'h00};
    tbl[6] = '{1, 1'b0, 3'd0, 8'h00, 8'h11};
    tbl[7] = '{1, 1'b0, 3'd6, 8'h00, INIT_V};

    req = 4'b1111; lock = '0; we = '0; addr = '0; wdata = '0;
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_gnt", gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rvalid", rvalid, 0);
    end
    chk("rst_rdata", rdata, 0);
    chk("rst_rid", rid, 0);
    req = '0;
    resetn = 1'b1;
    step();

    for (int a = 0; a < 8; a++) do_txn(0, 1'b0, 3'(a), 8'h00, INIT_V);
    for (int i = 0; i < 8; i++)
      do_txn(tbl[i].id, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

    // Reset lands on the edge that would complete a read.
    req = 4'b0100; we = '0; addr[6 +: 3] = 3'd3;
    step();
    chk("midrst_gnt", gnt, 4'b0100);
    resetn = 1'b0;
    step();
    chk("midrst_rvalid", rvalid, 0);
    chk("midrst_gnt0", gnt, 0);
    chk("midrst_busy", busy, 0);
    resetn = 1'b1; req = '0;
    step();
    chk("midrst_rvalid2", rvalid, 0);
    chk("midrst_busy2", busy, 0);
    do_txn(2, 1'b0, 3'd3, 8'h00, INIT_V);

    apply_reset(2);
    req = 4'b1111; we = '0; lock = '0;
    for (int i = 0; i < 4; i++) addr[i*3 +: 3] = 3'(i);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("fair_gnt", gnt, 32'(1) << (k % 4));
      if (k > 0) begin
        chk("fair_rvalid", rvalid, 1);
        chk("fair_rid", rid, (k - 1) % 4);
      end
    end
    req = '0;
    step();
    chk("fair_end_gnt", gnt, 0);
    chk("fair_end_rid", rid, 3);

    req = 4'b0010; lock = 4'b0010; we = '0; addr = '0; addr[3 +: 3] = 3'd1;
    step();
    chk("lock_gnt1", gnt, 4'b0010);
    req[0] = 1'b1;
    step();
    chk("lock_gnt2", gnt, 4'b0010);
    chk("lock_rv1", rvalid, 1);
    chk("lock_rid1", rid, 1);
    addr[3 +: 3] = 3'd2;
    step();
    chk("lock_gnt3", gnt, 4'b0010);
    chk("lock_rv2", rvalid, 1);
    lock = '0; addr[3 +: 3] = 3'd3;
    step();
    chk("lock_gnt_next", gnt, 4'b0001);
    chk("lock_rid3", rid, 1);
    req[1] = 1'b0;
    step();
    chk("lock_done_gnt", gnt, 0);
    chk("lock_done_rid", rid, 0);
    req = '0;
    step();
    chk("lock_idle", busy, 0);

    apply_reset(2);
    model_reset();
    req = '0; lock = '0;
    for (int c = 0; c < 600; c++) begin
      prev = m_owner;
      model_edge();
      step();
      chk("rnd_gnt", gnt, (m_owner < 0) ? 0 : (32'(1) << m_owner));
      chk("rnd_busy", busy, m_owner >= 0);
      chk("rnd_rvalid", rvalid, m_rv);
      if (m_rv) begin
        chk("rnd_rdata", rdata, m_rd);
        chk("rnd_rid", rid, m_rid);
      end
      for (int i = 0; i < 4; i++) begin
        if (i == prev) begin
          if (m_owner == i) new_access(i, $urandom_range(0, 1) == 1);
          else if ($urandom_range(0, 1) == 1) new_access(i, $urandom_range(0, 3) == 0);
          else begin
            req[i] = 1'b0; lock[i] = 1'b0;
          end
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          new_access(i, $urandom_range(0, 3) == 0);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin arbiter and sequencer for a shared bank of DEPTH x WIDTH positive-edge registers built from our Gowin flip-flop models. It lets NREQ requesters read or write the bank through a registered request/grant handshake, with optional locking for back-to-back bursts. It sits between the requesters and the register bank inside the Verilator-compatible primitive library.

## Interface
- NREQ, 4: number of requesters, 2..8
- WIDTH, 8: data width of each bank entry
- AW, 3: address width; DEPTH = 2**AW entries
- INIT, 0: reset value of every bank entry, WIDTH bits
- CLK  in  1  single clock; all state updates on its rising edge
- RESETN  in  1  reset, synchronous and active-low
- REQ  in  NREQ  per-requester access request
- LOCK  in  NREQ  per-requester burst lock, sampled with REQ
- WE  in  NREQ  per-requester write enable (1 = write, 0 = read)
- ADDR  in  NREQ*AW  per-requester address; requester i uses slice [i*AW +: AW]
- WDATA  in  NREQ*WIDTH  per-requester write data, slice [i*WIDTH +: WIDTH]
- GNT  out  NREQ  one-hot grant, registered
- RVALID  out  1  read data valid, one-cycle pulse
- RDATA  out  WIDTH  read data
- RID  out  clog2(NREQ)  index of the requester owning RDATA
- BUSY  out  1  high whenever the FSM is not IDLE

## Operation
- FSM states: IDLE, GRANT, LOCKED.
- IDLE: with any REQ high, go to GRANT with GNT = winner. Otherwise stay in IDLE.
- Winner selection: the lowest index at or after PTR (cyclic) with an eligible REQ.
- GRANT / LOCKED, current owner w:
  - The access executes in this cycle using WE[w], ADDR[w] and WDATA[w].
  - Write: the bank entry updates at the end of the cycle.
  - Read: RDATA, RVALID and RID = w appear in the next cycle.
- Leaving GRANT / LOCKED:
  - If LOCK[w] and REQ[w] are both high, go to LOCKED, keep GNT = w and leave PTR unchanged.
  - Otherwise set PTR = (w+1) mod NREQ. In this arbitration REQ[w] is masked, because it is stale.
  - Then go to GRANT with the new winner if one exists, else to IDLE with GNT = 0.
- Requester rules:
  - Hold REQ, WE, ADDR and WDATA stable from REQ assertion through the GNT cycle.
  - Deassert REQ in the cycle after GNT, unless another access is wanted.
- A request arriving in the same cycle a grant ends is arbitrated immediately. There is no idle bubble.
- A read-after-write to the same address in consecutive grants returns the new data.
- RVALID pulses exactly once per read grant. Writes never produce RVALID.
- Synchronous reset (RESETN = 0 at a rising edge) takes effect regardless of state or any in-flight access:
  - FSM goes to IDLE, PTR = 0, GNT = 0, RVALID = 0, RDATA = 0, RID = 0, BUSY = 0.
  - Every bank entry = INIT.
  - A pending read result is discarded.

## Timing
- REQ high at edge n: GNT is high from edge n+1, for one cycle when LOCK is low.
- Read: RDATA, RVALID and RID are valid from edge n+2 for one cycle.
- Write: the bank holds the new value after edge n+2.
- Sustained throughput is 1 access per cycle. With all NREQ requesters continuously requesting, each is granted once every NREQ cycles.
- LOCKED lasts as long as REQ[w] and LOCK[w] stay high. Starvation of other requesters is the owner's responsibility.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- A shared package `gowin_arb_pkg` holds:
  - the state encoding: IDLE = 2'd0, GRANT = 2'd1, LOCKED = 2'd2
  - a clog2 helper function
- One sub-module, `rr_pick`: a combinational round-robin selector from (req mask, PTR) to a one-hot winner plus a valid flag.
- The bank is an array of WIDTH-bit registers inside the top level.

## Test plan
- Reset: hold RESETN = 0 for 2 cycles with REQ = 4'b1111 → GNT = 0, BUSY = 0, RVALID = 0, and a read of every address returns INIT.
- Single write/read: requester 2 writes 8'hA5 to address 3, then reads address 3 → GNT = 4'b0100 at n+1, and on the read RVALID = 1, RDATA = 8'hA5, RID = 2.
- Fairness: REQ = 4'b1111 held for 8 cycles, no LOCK → grant order 0,1,2,3,0,1,2,3 with no idle cycle.
- Lock: requester 1 asserts LOCK with 3 back-to-back reads while requester 0 also requests → GNT = 4'b0010 for 3 cycles, then 4'b0001.
- Reset mid-read: RESETN goes low in the GNT cycle of a read → no RVALID, and state is IDLE afterwards.
- Boundary: with PTR = 3, only requester 3 requests repeatedly → requester 3 is granted in consecutive grants, and the address 7 write/read wraps correctly.
